// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-side transmitter and receiver.
// Holds the FSM state encodings, default timing constants for a 50 MHz clk,
// the ps2c filter depth and a parity helper.
package ps2_pkg;

    // Default timing at 50 MHz: 120 us request-to-send, 15 ms edge timeout.
    localparam int RTS_CYCLES_DEF     = 6000;
    localparam int TIMEOUT_CYCLES_DEF = 750000;

    // Number of consecutive equal ps2c samples needed to change the filtered clock.
    localparam int FILTER_DEPTH = 8;

    // Transmitter FSM encodings.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RTS   = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;
    localparam logic [2:0] ST_ACK   = 3'd5;

    // PS/2 uses odd parity: the parity bit makes the count of ones in
    // {parity, data} odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Purpose: debounce the raw PS/2 clock and flag its falling edges.
// Latency: neg_edge asserts FILTER_DEPTH cycles after ps2c is first sampled low.
// Backpressure: none; free-running, one neg_edge pulse per filtered fall.
//
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   ps2c_in     - raw (resolved) PS/2 clock line
//   neg_edge    - one-cycle pulse, filtered clock is 1 now and 0 next cycle
module ps2_clk_filter
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic ps2c_in,
    output logic neg_edge
);

    logic [FILTER_DEPTH-1:0] filt_q, filt_d;
    logic                    f_val_q, f_val_d;

    always_comb begin
        filt_d  = {ps2c_in, filt_q[FILTER_DEPTH-1:1]};
        f_val_d = f_val_q;
        // Only a full window of identical samples moves the filtered value;
        // anything mixed is treated as noise and the old value holds.
        if (&filt_q) begin
            f_val_d = 1'b1;
        end else if (~|filt_q) begin
            f_val_d = 1'b0;
        end
        neg_edge = f_val_q & ~f_val_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q  <= '0;
            f_val_q <= 1'b0;
        end else begin
            filt_q  <= filt_d;
            f_val_q <= f_val_d;
        end
    end

endmodule

// File: rtl/ps2_tx.sv
// Purpose: PS/2 host-to-device byte transmitter with ack and edge-timeout checking.
// Latency: RTS_CYCLES of clock inhibit, then one bit per device clock (12 falling edges).
// Backpressure: wr_ps2 accepted only while tx_idle=1; writes at other times are dropped.
//
// Ports:
//   clk, reset    - system clock, synchronous active-high reset
//   wr_ps2, din   - write strobe and byte to send (latched when accepted)
//   ps2c, ps2d    - open-drain PS/2 clock and data (driven 0 or released)
//   tx_idle       - high only in idle; feeds the receiver's enable
//   tx_done_tick  - one-cycle pulse at the end of every transaction
//   ack_err       - device did not pull data low on the ack bit
//   tmo_err       - transaction abandoned because the device stopped clocking
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int RTS_CYCLES     = RTS_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       ack_err,
    output logic       tmo_err
);

    // +1 so the widths still hold the largest loaded value when a parameter
    // is an exact power of two.
    localparam int TMR_W = $clog2(RTS_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [TMR_W-1:0] RTS_LOAD = TMR_W'(RTS_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state_q,   state_d;
    logic [8:0]       sh_q,      sh_d;       // {parity, D7..D0}, LSB goes out first
    logic [3:0]       n_q,       n_d;        // bits remaining after the current one
    logic [TMR_W-1:0] timer_q,   timer_d;
    logic [TMO_W-1:0] tmo_q,     tmo_d;
    logic             ack_err_q, ack_err_d;
    logic             tmo_err_q, tmo_err_d;
    logic             done_q,    done_d;

    logic             neg_edge;
    logic             ps2c_low;
    logic             ps2d_low;
    logic             edge_watch;

    ps2_clk_filter u_filter (
        .clk      (clk),
        .reset    (reset),
        .ps2c_in  (ps2c),
        .neg_edge (neg_edge)
    );

    // Once the host hands the clock to the device, every state waits on a
    // device edge and is guarded by the same inter-edge timeout.
    assign edge_watch = (state_q == ST_START) || (state_q == ST_DATA) ||
                        (state_q == ST_STOP)  || (state_q == ST_ACK);

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        n_d       = n_q;
        timer_d   = timer_q;
        tmo_d     = tmo_q;
        ack_err_d = ack_err_q;
        tmo_err_d = tmo_err_q;
        done_d    = 1'b0;
        ps2c_low  = 1'b0;
        ps2d_low  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wr_ps2) begin
                    sh_d      = {odd_parity(din), din};
                    ack_err_d = 1'b0;
                    tmo_err_d = 1'b0;
                    timer_d   = RTS_LOAD;
                    state_d   = ST_RTS;
                end
            end

            ST_RTS: begin
                // Inhibit the device by holding its clock low.
                ps2c_low = 1'b1;
                tmo_d    = '0;
                if (timer_q == '0) begin
                    state_d = ST_START;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end

            ST_START: begin
                // Data low with clock released is the request-to-send
                // start condition; the device now generates the clock.
                ps2d_low = 1'b1;
                if (neg_edge) begin
                    n_d     = 4'd8;
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                ps2d_low = ~sh_q[0];
                if (neg_edge) begin
                    sh_d = {1'b0, sh_q[8:1]};
                    if (n_q == 4'd0) begin
                        state_d = ST_STOP;
                    end else begin
                        n_d = n_q - 4'd1;
                    end
                end
            end

            ST_STOP: begin
                // Stop bit is a released (high) data line.
                if (neg_edge) begin
                    state_d = ST_ACK;
                end
            end

            ST_ACK: begin
                if (neg_edge) begin
                    ack_err_d = ps2d;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A device edge restarts the watchdog; the edge always takes priority
        // over an expiry landing in the same cycle.
        if (edge_watch) begin
            if (neg_edge) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                tmo_d     = '0;
                tmo_err_d = 1'b1;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sh_q      <= '0;
            n_q       <= '0;
            timer_q   <= '0;
            tmo_q     <= '0;
            ack_err_q <= 1'b0;
            tmo_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            n_q       <= n_d;
            timer_q   <= timer_d;
            tmo_q     <= tmo_d;
            ack_err_q <= ack_err_d;
            tmo_err_q <= tmo_err_d;
            done_q    <= done_d;
        end
    end

    // Open-drain: only ever pull low, otherwise float for the pull-up.
    assign ps2c = ps2c_low ? 1'b0 : 1'bz;
    assign ps2d = ps2d_low ? 1'b0 : 1'bz;

    assign tx_idle      = (state_q == ST_IDLE);
    assign tx_done_tick = done_q;
    assign ack_err      = ack_err_q;
    assign tmo_err      = tmo_err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with a PS/2 device model on pulled-up open-drain lines.
// A frame takes 12 device falling edges: start, nine in data (D0..D7, parity), stop, ack.
// Frame words are {stop, parity, D7..D0, start}, sampled before each falling edge.
module tb_ps2_tx;

    localparam int RTS  = 6000;
    localparam int TMO  = 3000;
    localparam int HALF = 24;     // device clock half-period in clk cycles

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_ps2;
    logic [7:0] din;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;
    logic       tx_idle, tx_done_tick, ack_err, tmo_err;

    wire ps2c;
    wire ps2d;
    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c_low ? 1'b0 : 1'bz;
    assign ps2d = dev_d_low ? 1'b0 : 1'bz;

    int checks   = 0;
    int passed   = 0;
    int fails    = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    ps2_tx #(.RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_ps2       (wr_ps2),
        .din          (din),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .tx_idle      (tx_idle),
        .tx_done_tick (tx_done_tick),
        .ack_err      (ack_err),
        .tmo_err      (tmo_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done_tick) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write(input logic [7:0] b);
        @(negedge clk);
        din    = b;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
    endtask

    // Counts the clk cycles ps2c is held low by the host after a write.
    task automatic wait_rts(output int len);
        len = 0;
        for (int i = 0; i < 20 && ps2c !== 1'b0; i++) @(negedge clk);
        while (ps2c === 1'b0 && len < RTS + 1000) begin
            len++;
            @(negedge clk);
        end
    endtask

    // Device model: generates n_edges falling edges on ps2c and samples ps2d
    // just before each fall. Optional ack pull after the 11th fall, a 4-cycle
    // clock glitch in the high phase after edge glitch_e, and a stray 8'hFF
    // write in the low phase after edge wr_e.
    task automatic frame(input int n_edges, input bit do_ack, input int glitch_e,
                         input int wr_e, output logic [10:0] bits, output int last_fall);
        bits      = '0;
        last_fall = 0;
        tick(HALF);
        bits[0] = ps2d;
        for (int e = 1; e <= n_edges; e++) begin
            dev_c_low = 1'b1;
            last_fall = cyc;
            if (e == 11 && do_ack) dev_d_low = 1'b1;
            if (e == wr_e) begin
                tick(12);
                din    = 8'hFF;
                wr_ps2 = 1'b1;
                tick(1);
                wr_ps2 = 1'b0;
                tick(HALF - 13);
            end else begin
                tick(HALF);
            end
            dev_c_low = 1'b0;
            if (e == glitch_e) begin
                tick(8);
                dev_c_low = 1'b1;
                tick(4);
                dev_c_low = 1'b0;
                tick(HALF - 12);
            end else begin
                tick(HALF);
            end
            if (e <= 10) bits[e] = ps2d;
        end
        dev_d_low = 1'b0;
    endtask

    initial begin
        logic [10:0] bits;
        int          lf;
        int          len;
        int          d0;
        int          lows;

        reset  = 1'b1;
        wr_ps2 = 1'b0;
        din    = 8'h00;

        // Reset state after the first edge with reset high.
        @(negedge clk);
        chk("rst_tx_idle", tx_idle, 1);
        chk("rst_done", tx_done_tick, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_tmo_err", tmo_err, 0);
        chk("rst_ps2c", ps2c, 1);
        chk("rst_ps2d", ps2d, 1);
        tick(3);
        reset = 1'b0;
        tick(20);

        // 8'hED with ack: D0..D7 = 1,0,1,1,0,1,1,1, parity 1 -> 11'h7DA.
        d0 = done_cnt;
        write(8'hED);
        chk("ed_not_idle", tx_idle, 0);
        wait_rts(len);
        chk("ed_rts_len", len, RTS);
        frame(12, 1'b1, 0, 0, bits, lf);
        tick(5);
        chk("ed_bits", bits, 11'h7DA);
        chk("ed_done_cnt", done_cnt - d0, 1);
        chk("ed_done_lat", done_cyc - lf, 9);
        chk("ed_ack_err", ack_err, 0);
        chk("ed_tmo_err", tmo_err, 0);
        chk("ed_idle", tx_idle, 1);

        // 8'h00 without ack: parity 1 -> 11'h600, ack_err set.
        d0 = done_cnt;
        write(8'h00);
        wait_rts(len);
        frame(12, 1'b0, 0, 0, bits, lf);
        tick(5);
        chk("nak_bits", bits, 11'h600);
        chk("nak_done_cnt", done_cnt - d0, 1);
        chk("nak_ack_err", ack_err, 1);
        chk("nak_tmo_err", tmo_err, 0);

        // Device stops after start + 3 data edges; D3 of 8'hA0 is 0, so ps2d
        // is held low when the watchdog fires.
        d0 = done_cnt;
        write(8'hA0);
        wait_rts(len);
        frame(4, 1'b0, 0, 0, bits, lf);
        for (int i = 0; i < TMO + 200 && done_cnt == d0; i++) @(negedge clk);
        tick(2);
        chk("tmo_done_cnt", done_cnt - d0, 1);
        chk("tmo_done_lat", done_cyc - lf, 9 + TMO);
        chk("tmo_tmo_err", tmo_err, 1);
        chk("tmo_ps2c", ps2c, 1);
        chk("tmo_ps2d", ps2d, 1);
        chk("tmo_idle", tx_idle, 1);

        // Stray 8'hFF write during data: 8'h5A must go out intact -> 11'h6B4.
        d0 = done_cnt;
        write(8'h5A);
        wait_rts(len);
        frame(12, 1'b1, 0, 5, bits, lf);
        tick(5);
        chk("wr_bits", bits, 11'h6B4);
        chk("wr_done_cnt", done_cnt - d0, 1);
        chk("wr_ack_err", ack_err, 0);
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            if (ps2c === 1'b0) lows++;
            @(negedge clk);
        end
        chk("wr_no_second_rts", lows, 0);
        chk("wr_idle", tx_idle, 1);

        // 4-cycle ps2c glitch during data: 8'h3C, parity 1 -> 11'h678, and
        // completion still on the 12th edge.
        d0 = done_cnt;
        write(8'h3C);
        wait_rts(len);
        frame(12, 1'b1, 5, 0, bits, lf);
        tick(5);
        chk("gl_bits", bits, 11'h678);
        chk("gl_done_cnt", done_cnt - d0, 1);
        chk("gl_done_lat", done_cyc - lf, 9);
        chk("gl_ack_err", ack_err, 0);

        // Reset during rts aborts silently; then 8'hF4 (parity 0) -> 11'h5E8.
        d0 = done_cnt;
        write(8'hF4);
        tick(100);
        chk("rr_in_rts", ps2c, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rr_idle", tx_idle, 1);
        chk("rr_ps2c", ps2c, 1);
        chk("rr_ps2d", ps2d, 1);
        chk("rr_done", tx_done_tick, 0);
        reset = 1'b0;
        tick(20);
        chk("rr_no_done", done_cnt - d0, 0);
        write(8'hF4);
        wait_rts(len);
        chk("f4_rts_len", len, RTS);
        frame(12, 1'b1, 0, 0, bits, lf);
        tick(5);
        chk("f4_bits", bits, 11'h5E8);
        chk("f4_done_cnt", done_cnt - d0, 1);
        chk("f4_ack_err", ack_err, 0);
        chk("f4_tmo_err", tmo_err, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
